// File: rtl/id_issue_ctrl.sv
// Issue and hazard controller for the decode front end.
// Tracks pending long-latency GPR writes in a scoreboard, stalls the ID
// instruction on RAW/WAW hazards or EX back-pressure, and sequences the
// IF/ID and ID/EX flushes that follow a control-flow redirect from EX.
module id_issue_ctrl #(
    parameter int unsigned RegAddrWidth = 5,
    parameter int unsigned NumRegs      = 32,
    parameter int unsigned FlushCycles  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    id_valid,
    input  logic [RegAddrWidth-1:0] rs1_addr,
    input  logic [RegAddrWidth-1:0] rs2_addr,
    input  logic [RegAddrWidth-1:0] rd_addr,
    input  logic                    rs1_used,
    input  logic                    rs2_used,
    input  logic                    rd_wr,
    input  logic                    long_lat,
    input  logic                    ex_ready,
    input  logic                    wb_valid,
    input  logic [RegAddrWidth-1:0] wb_rd_addr,
    input  logic                    redirect,
    output logic                    issue,
    output logic                    stall_if,
    output logic                    stall_id,
    output logic                    flush_if_id,
    output logic                    flush_id_ex,
    output logic [NumRegs-1:0]      busy_mask
);

    localparam int unsigned CntW = (FlushCycles > 1) ? $clog2(FlushCycles) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(FlushCycles - 1);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [NumRegs-1:0]  busy_q, busy_d;

    logic [NumRegs-1:0]  clr;
    logic [NumRegs-1:0]  set;
    logic [NumRegs-1:0]  eff;
    logic                haz;
    logic                in_run;
    logic                active;
    logic                redir;

    // Scoreboard view with same-cycle writeback bypass, and the hazard test
    always_comb begin
        clr = '0;
        if (wb_valid) begin
            clr = NumRegs'(1) << wb_rd_addr;
        end
        eff = busy_q & ~clr;
        haz = id_valid & ((rs1_used & eff[rs1_addr]) |
                          (rs2_used & eff[rs2_addr]) |
                          (rd_wr    & eff[rd_addr]));
    end

    // Pipeline controls; a redirect is ignored until the controller leaves INIT
    always_comb begin
        in_run      = (state_q == ST_RUN);
        active      = (state_q != ST_INIT);
        redir       = active & redirect;
        issue       = in_run & ~redir & id_valid & ~haz & ex_ready;
        stall_id    = in_run & ~redir & id_valid & ~issue;
        stall_if    = stall_id;
        flush_id_ex = redir | stall_id;
        flush_if_id = redir | (state_q == ST_FLUSH);
    end

    // Next scoreboard contents, flush counter and state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        set     = '0;
        if (issue && rd_wr && long_lat && (rd_addr != '0)) begin
            set = NumRegs'(1) << rd_addr;
        end
        busy_d    = active ? ((busy_q & ~clr) | set) : busy_q;
        busy_d[0] = 1'b0;

        case (state_q)
            ST_INIT: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
            ST_RUN: begin
                if (redirect && (FlushCycles > 1)) begin
                    state_d = ST_FLUSH;
                    cnt_d   = CntLoad;
                end
            end
            ST_FLUSH: begin
                if (redirect) begin
                    cnt_d = CntLoad;
                end else if (cnt_q <= CntW'(1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and scoreboard registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign busy_mask = busy_q;

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Self-checking bench for id_issue_ctrl: hand-computed vector table,
// a reset-during-flush sequence, then random traffic against a model.
module tb_id_issue_ctrl;

    localparam int unsigned AW = 5;
    localparam int unsigned NR = 32;
    localparam int unsigned FC = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid, rs1_used, rs2_used, rd_wr, long_lat, ex_ready, wb_valid, redirect;
    logic [AW-1:0] rs1_addr, rs2_addr, rd_addr, wb_rd_addr;
    logic          issue, stall_if, stall_id, flush_if_id, flush_id_ex;
    logic [NR-1:0] busy_mask;

    int n_chk = 0;
    int n_err = 0;

    id_issue_ctrl #(.RegAddrWidth(AW), .NumRegs(NR), .FlushCycles(FC)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .rs1_used(rs1_used), .rs2_used(rs2_used), .rd_wr(rd_wr), .long_lat(long_lat),
        .ex_ready(ex_ready), .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr),
        .redirect(redirect), .issue(issue), .stall_if(stall_if), .stall_id(stall_id),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .busy_mask(busy_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          idv;
        logic [AW-1:0] rs1, rs2, rd;
        logic          u1, u2, wr, ll, rdy, wbv;
        logic [AW-1:0] wbr;
        logic          redir;
        logic          e_iss, e_stall, e_fif, e_fie;
        logic [NR-1:0] e_busy;
    } vec_t;

    vec_t vecs[$];

    // Behavioural reference: per-register pending flags and a pipeline phase
    bit m_busy[NR];
    int m_phase;       // 0 = just out of reset, 1 = running, 2 = flushing
    int m_flush_left;  // flush-only cycles still to come
    logic x_iss, x_stall, x_fif, x_fie;
    logic [NR-1:0] x_busy;

    function automatic vec_t mk(input int idv, input int rs1, input int rs2, input int rd,
                                input int u1, input int u2, input int wr, input int ll,
                                input int rdy, input int wbv, input int wbr, input int redir,
                                input int ei, input int es, input int ef1, input int ef2,
                                input int eb);
        vec_t v;
        v.idv = 1'(idv); v.rs1 = AW'(rs1); v.rs2 = AW'(rs2); v.rd = AW'(rd);
        v.u1 = 1'(u1); v.u2 = 1'(u2); v.wr = 1'(wr); v.ll = 1'(ll);
        v.rdy = 1'(rdy); v.wbv = 1'(wbv); v.wbr = AW'(wbr); v.redir = 1'(redir);
        v.e_iss = 1'(ei); v.e_stall = 1'(es); v.e_fif = 1'(ef1); v.e_fie = 1'(ef2);
        v.e_busy = NR'(eb);
        return v;
    endfunction

    task automatic check(input string name, input logic [NR-1:0] act, input logic [NR-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        id_valid = v.idv; rs1_addr = v.rs1; rs2_addr = v.rs2; rd_addr = v.rd;
        rs1_used = v.u1; rs2_used = v.u2; rd_wr = v.wr; long_lat = v.ll;
        ex_ready = v.rdy; wb_valid = v.wbv; wb_rd_addr = v.wbr; redirect = v.redir;
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(NR); i++) m_busy[i] = 1'b0;
        m_phase = 0;
        m_flush_left = 0;
    endtask

    function automatic bit pending(input logic [AW-1:0] r);
        return m_busy[r] && !(wb_valid && (wb_rd_addr == r));
    endfunction

    // Expected outputs for the current phase and the inputs now applied
    task automatic model_eval();
        bit blocked, redir, go;
        blocked = id_valid && ((rs1_used && pending(rs1_addr)) ||
                               (rs2_used && pending(rs2_addr)) ||
                               (rd_wr && pending(rd_addr)));
        redir   = (m_phase != 0) && redirect;
        go      = (m_phase == 1) && !redir && id_valid;
        x_iss   = go && !blocked && ex_ready;
        x_stall = go && !x_iss;
        x_fie   = redir || x_stall;
        x_fif   = redir || (m_phase == 2);
        for (int i = 0; i < int'(NR); i++) x_busy[i] = m_busy[i];
    endtask

    // Advance the model by one clock edge
    task automatic model_step();
        if (m_phase != 0 && wb_valid) m_busy[wb_rd_addr] = 1'b0;
        if (x_iss && rd_wr && long_lat && rd_addr != 0) m_busy[rd_addr] = 1'b1;
        if (m_phase == 0) begin
            m_phase = 1;
        end else if (redirect) begin
            m_flush_left = FC - 1;
            m_phase = (m_flush_left > 0) ? 2 : 1;
        end else if (m_phase == 2) begin
            m_flush_left--;
            if (m_flush_left == 0) m_phase = 1;
        end
    endtask

    task automatic compare_outputs(input string tag, input logic ei, input logic es,
                                   input logic ef1, input logic ef2, input logic [NR-1:0] eb);
        check({tag, ".issue"}, NR'(issue), NR'(ei));
        check({tag, ".stall_if"}, NR'(stall_if), NR'(es));
        check({tag, ".stall_id"}, NR'(stall_id), NR'(es));
        check({tag, ".flush_if_id"}, NR'(flush_if_id), NR'(ef1));
        check({tag, ".flush_id_ex"}, NR'(flush_id_ex), NR'(ef2));
        check({tag, ".busy_mask"}, busy_mask, eb);
    endtask

    // Sample at the falling edge, then advance the model on the rising edge
    task automatic cycle_model(input string tag);
        @(negedge clk);
        model_eval();
        compare_outputs(tag, x_iss, x_stall, x_fif, x_fie, x_busy);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cycle_table(input int idx, input vec_t v);
        @(negedge clk);
        model_eval();
        compare_outputs($sformatf("vec%0d", idx), v.e_iss, v.e_stall, v.e_fif, v.e_fie, v.e_busy);
        @(posedge clk);
        model_step();
        #1;
    endtask

    vec_t idle;

    initial begin
        idle = mk(0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0);
        //          idv rs1 rs2 rd u1 u2 wr ll rdy wbv wbr rdr  iss stl fif fie busy
        vecs.push_back(mk(1,5,0,0, 1,0,0,0, 1,0,0,0, 0,0,0,0, 0));       // INIT cycle
        vecs.push_back(mk(1,5,0,0, 1,0,0,0, 1,0,0,0, 1,0,0,0, 0));       // first issue
        vecs.push_back(mk(1,0,0,7, 0,0,1,1, 1,0,0,0, 1,0,0,0, 0));       // load to x7
        vecs.push_back(mk(1,0,7,0, 0,1,0,0, 1,0,0,0, 0,1,0,1, 'h80));    // RAW stall
        vecs.push_back(mk(1,0,7,0, 0,1,0,0, 1,0,0,0, 0,1,0,1, 'h80));
        vecs.push_back(mk(1,0,7,0, 0,1,0,0, 1,1,7,0, 1,0,0,0, 'h80));    // wb bypass
        vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0));
        vecs.push_back(mk(1,0,0,0, 0,0,1,1, 1,0,0,0, 1,0,0,0, 0));       // long op to x0
        vecs.push_back(mk(1,0,0,0, 1,0,0,0, 1,0,0,0, 1,0,0,0, 0));       // x0 consumer
        vecs.push_back(mk(1,0,0,9, 0,0,1,1, 1,0,0,0, 1,0,0,0, 0));       // long op to x9
        vecs.push_back(mk(1,0,0,9, 0,0,1,1, 1,1,9,0, 1,0,0,0, 'h200));  // wb x9 + new x9
        vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0, 'h200));  // set won
        vecs.push_back(mk(1,3,0,0, 1,0,0,0, 0,0,0,0, 0,1,0,1, 'h200));  // EX not ready
        vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0,1,9,0, 0,0,0,0, 'h200));
        vecs.push_back(mk(1,3,0,0, 1,0,0,0, 1,0,0,1, 0,0,1,1, 0));       // redirect
        vecs.push_back(mk(1,3,0,0, 1,0,0,0, 1,0,0,0, 0,0,1,0, 0));       // FLUSH
        vecs.push_back(mk(1,3,0,0, 1,0,0,0, 1,0,0,0, 1,0,0,0, 0));       // RUN again
        vecs.push_back(mk(1,3,0,0, 1,0,0,0, 1,0,0,1, 0,0,1,1, 0));       // redirect
        vecs.push_back(mk(1,3,0,0, 1,0,0,0, 1,0,0,1, 0,0,1,1, 0));       // redirect in FLUSH
        vecs.push_back(mk(1,3,0,0, 1,0,0,0, 1,0,0,0, 0,0,1,0, 0));       // extended FLUSH
        vecs.push_back(mk(1,3,0,0, 1,0,0,0, 1,0,0,0, 1,0,0,0, 0));

        rst_n = 1'b0;
        drive(idle);
        model_reset();
        @(negedge clk);
        compare_outputs("reset", 1'b0, 1'b0, 1'b0, 1'b0, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            cycle_table(i, vecs[i]);
        end

        // Mark x2 and x7 busy, redirect, then reset while flushing
        drive(mk(1,0,0,2, 0,0,1,1, 1,0,0,0, 0,0,0,0, 0));
        cycle_model("ld_x2");
        drive(mk(1,0,0,7, 0,0,1,1, 1,0,0,0, 0,0,0,0, 0));
        cycle_model("ld_x7");
        drive(mk(1,2,0,0, 1,0,0,0, 1,0,0,1, 0,0,0,0, 0));
        cycle_model("redir");
        drive(mk(1,2,0,0, 1,0,0,0, 1,0,0,1, 0,0,0,0, 0));
        @(negedge clk);
        check("pre_rst.busy_mask", busy_mask, NR'('h84));
        check("pre_rst.flush_if_id", NR'(flush_if_id), NR'(1));
        rst_n = 1'b0;
        #1;
        compare_outputs("mid_flush_rst", 1'b0, 1'b0, 1'b0, 1'b0, '0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Random traffic over a small register window to provoke hazards
        for (int c = 0; c < 400; c++) begin
            id_valid   = ($urandom_range(3) != 0);
            rs1_addr   = AW'($urandom_range(7));
            rs2_addr   = AW'($urandom_range(7));
            rd_addr    = AW'($urandom_range(7));
            rs1_used   = 1'($urandom_range(1));
            rs2_used   = 1'($urandom_range(1));
            rd_wr      = 1'($urandom_range(1));
            long_lat   = 1'($urandom_range(1));
            ex_ready   = ($urandom_range(3) != 0);
            wb_valid   = ($urandom_range(2) == 0);
            wb_rd_addr = AW'($urandom_range(7));
            redirect   = ($urandom_range(11) == 0);
            cycle_model($sformatf("rnd%0d", c));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
